div_scheduler: RTL and testbench
================================

DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter N, default 4, operand width of the shared divider.
REQ-002 Parameter R, default 4, number of requesters sharing the divider.
REQ-003 Parameter TMO, default N+3, cycles allowed in RUN before watchdog error.
REQ-004 clock  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  R  per-requester operation request.
REQ-007 req_ready  output  R  per-requester accept, one-hot or zero.
REQ-008 req_dividend  input  R*N  requester i operand at bits [i*N +: N].
REQ-009 req_divisor  input  R*N  requester i divisor at bits [i*N +: N].
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_id  output  clog2(R), minimum 1  index of the requester that owns the result.
REQ-013 resp_quotient, resp_remainder  output  N each  result.
REQ-014 resp_divzero, resp_timeout  output  1 each  error flags.
REQ-015 div_load  output  1  divider load/restart strobe.
REQ-016 div_dividend, div_divisor  output  N each  operands to the divider.
REQ-017 div_q, div_a  input  N each  divider quotient and remainder.
REQ-018 div_done  input  1  divider completion flag.

Function
REQ-019 The block SHALL implement states IDLE, LOAD, RUN and RESP.
REQ-020 In IDLE, the block SHALL grant the first asserted req_valid found searching from rr_ptr upward with wrap-around, and SHALL assert req_ready only for that index, combinationally, in the same cycle.
REQ-021 On grant, the block SHALL latch the operands and the id; the next state SHALL be RESP when the divisor is 0, otherwise LOAD.
REQ-022 On a divide-by-zero grant, the block SHALL set resp_quotient to all ones, resp_remainder to the dividend and resp_divzero to 1, and SHALL NOT pulse div_load.
REQ-023 In LOAD, div_load SHALL be 1 for exactly one cycle, with div_dividend and div_divisor driven from the latched operands; the next state is RUN.
REQ-024 div_dividend and div_divisor SHALL hold their latched values in every state.
REQ-025 In RUN, the block SHALL capture div_q and div_a into the response registers in the first cycle div_done==1, then enter RESP; capture SHALL be one-shot because the divider keeps iterating after done.
REQ-026 div_done==1 in the first RUN cycle SHALL be ignored as stale.
REQ-027 A RUN cycle counter SHALL set resp_timeout=1, zero the quotient and remainder, and enter RESP if div_done has not been captured after TMO cycles.
REQ-028 In RESP, resp_valid SHALL be 1, and all resp_* outputs SHALL be stable until resp_valid and resp_ready are both 1 in the same cycle.
REQ-029 On that handshake, the block SHALL clear the error flags, set rr_ptr to (granted id+1) mod R and return to IDLE; no new grant SHALL occur in that cycle.
REQ-030 req_ready SHALL be 0 in LOAD, RUN and RESP, so only one operation is outstanding at a time.
REQ-031 Nominal latency from grant to resp_valid SHALL be N+2 cycles; divide-by-zero latency SHALL be 1 cycle.
REQ-032 Requests SHALL NOT be dropped; a non-granted request SHALL remain pending while its valid is held.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter IDLE, with rr_ptr=0, req_ready=0, resp_valid=0, all resp_* outputs=0, div_load=0, div_dividend=0 and div_divisor=0.
REQ-034 Reset mid-operation, in any state, SHALL abandon the operation with no response produced; after reset, the next grant starts from requester 0.

Verification
REQ-035 The bench SHALL cover: N=4, R=4, requester 0 requests 7/2 -> req_ready[0] in the same cycle; resp_valid 6 cycles later with quotient=3, remainder=1, resp_id=0.
REQ-036 The bench SHALL cover: all four req_valid held high, resp_ready=1 -> grants in order 0, 1, 2, 3, 0, one response each.
REQ-037 The bench SHALL cover: divisor 0, dividend 5 -> next cycle resp_valid with quotient=4'hF, remainder=5, resp_divzero=1, and no div_load pulse.
REQ-038 The bench SHALL cover: resp_ready held 0 for 5 cycles in RESP -> outputs stable, no new req_ready; on release, the handshake completes and IDLE is re-entered.
REQ-039 The bench SHALL cover: div_done tied 0 -> resp_timeout=1 after TMO RUN cycles, with quotient and remainder both 0.
REQ-040 The bench SHALL cover: reset pulsed during RUN -> no resp_valid; the next request is granted from requester 0 and completes correctly.

Source files
------------

// File: rtl/div_scheduler_if.sv
// Bundle of request, response and divider-side signals for div_scheduler.
// The "slave" modport is the scheduler's view; "master" is the environment
// (requesters, result consumer and the shared divider).
interface div_scheduler_if #(
  parameter int N  = 4,
  parameter int R  = 4,
  parameter int IW = (R > 1) ? $clog2(R) : 1
);
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_dividend;
  logic [R*N-1:0] req_divisor;

  logic           resp_valid;
  logic           resp_ready;
  logic [IW-1:0]  resp_id;
  logic [N-1:0]   resp_quotient;
  logic [N-1:0]   resp_remainder;
  logic           resp_divzero;
  logic           resp_timeout;

  logic           div_load;
  logic [N-1:0]   div_dividend;
  logic [N-1:0]   div_divisor;
  logic [N-1:0]   div_q;
  logic [N-1:0]   div_a;
  logic           div_done;

  modport master (
    output req_valid, req_dividend, req_divisor, resp_ready,
           div_q, div_a, div_done,
    input  req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_divzero, resp_timeout, div_load, div_dividend, div_divisor
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, resp_ready,
           div_q, div_a, div_done,
    output req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_divzero, resp_timeout, div_load, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one iterative divider among R requesters.
// One operation is outstanding at a time: IDLE grants, LOAD strobes the
// divider, RUN waits for completion (with a watchdog), RESP holds the result
// until the consumer takes it. Divide-by-zero bypasses the divider entirely.
module div_scheduler #(
  parameter int N   = 4,
  parameter int R   = 4,
  parameter int TMO = N + 3
) (
  input  logic              clock,
  input  logic              reset,
  div_scheduler_if.slave    io_bus
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_id;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dvs;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_rem;
  logic            r_dz;
  logic            r_to;
  logic            r_rv;
  logic            r_load;
  logic [CW-1:0]   r_run_cnt;

  logic            w_gnt_any;
  logic [IW-1:0]   w_gnt_id;
  logic [N-1:0]    w_gnt_dvd;
  logic [N-1:0]    w_gnt_dvs;
  logic [R-1:0]    w_ready;
  logic [IW-1:0]   w_next_ptr;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  // Scanning offsets high-to-low lets the smallest offset win.
  always_comb begin : p_grant
    int j;
    j         = 0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_gnt_dvd = '0;
    w_gnt_dvs = '0;
    for (int k = R - 1; k >= 0; k--) begin
      j = (int'(r_rr_ptr) + k) % R;
      if (io_bus.req_valid[j]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = IW'(j);
        w_gnt_dvd = io_bus.req_dividend[j*N +: N];
        w_gnt_dvs = io_bus.req_divisor[j*N +: N];
      end
    end
  end

  // Accept is combinational and only in IDLE; suppressed while reset is
  // asserted so no requester believes it was accepted by a discarded grant.
  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && !reset && w_gnt_any)
      w_ready[w_gnt_id] = 1'b1;
  end

  // Pointer moves one past the requester just served.
  always_comb begin
    w_next_ptr = r_id + IW'(1);
    if (r_id == IW'(R - 1))
      w_next_ptr = '0;
  end

  // Main FSM with all outputs registered; the divider may keep iterating
  // after done, so the result is captured exactly once on leaving RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
      r_to      <= 1'b0;
      r_rv      <= 1'b0;
      r_load    <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_id  <= w_gnt_id;
            r_dvd <= w_gnt_dvd;
            r_dvs <= w_gnt_dvs;
            r_to  <= 1'b0;
            if (w_gnt_dvs == '0) begin
              r_q     <= '1;
              r_rem   <= w_gnt_dvd;
              r_dz    <= 1'b1;
              r_rv    <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_dz    <= 1'b0;
              r_load  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_run_cnt <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          // done in the very first RUN cycle is left over from a prior op
          if (io_bus.div_done && r_run_cnt != '0) begin
            r_q     <= io_bus.div_q;
            r_rem   <= io_bus.div_a;
            r_rv    <= 1'b1;
            r_state <= S_RESP;
          end else if (r_run_cnt == CW'(TMO - 1)) begin
            r_q     <= '0;
            r_rem   <= '0;
            r_to    <= 1'b1;
            r_rv    <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_run_cnt <= r_run_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (io_bus.resp_ready) begin
            r_rv     <= 1'b0;
            r_dz     <= 1'b0;
            r_to     <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready      = w_ready;
  assign io_bus.resp_valid     = r_rv;
  assign io_bus.resp_id        = r_id;
  assign io_bus.resp_quotient  = r_q;
  assign io_bus.resp_remainder = r_rem;
  assign io_bus.resp_divzero   = r_dz;
  assign io_bus.resp_timeout   = r_to;
  assign io_bus.div_load       = r_load;
  assign io_bus.div_dividend   = r_dvd;
  assign io_bus.div_divisor    = r_dvs;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural iterative divider, table of single
// requests, scoreboard of expected responses, and hand sequences for
// round-robin, back-pressure, reset-in-RUN and watchdog timeout.
module tb_div_scheduler;
  localparam int N   = 4;
  localparam int R   = 4;
  localparam int TMO = N + 3;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  div_scheduler_if #(.N(N), .R(R)) bus ();

  div_scheduler #(.N(N), .R(R), .TMO(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .io_bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural divider: results valid N cycles after load, done stays high
  // afterwards, and done is also (stale) high in the first cycle after load
  // while the outputs are still garbage.
  logic [N-1:0] m_q, m_a;
  int           m_cnt;
  logic         m_busy, m_first, tie0;
  int           load_cnt;

  always @(posedge clock) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_first <= 1'b0;
      m_cnt   <= 0;
    end else if (bus.div_load) begin
      m_busy  <= 1'b1;
      m_first <= 1'b1;
      m_cnt   <= 0;
      if (bus.div_divisor != 0) begin
        m_q <= bus.div_dividend / bus.div_divisor;
        m_a <= bus.div_dividend % bus.div_divisor;
      end
    end else begin
      m_first <= 1'b0;
      if (m_busy && m_cnt < 15) m_cnt <= m_cnt + 1;
    end
  end

  assign bus.div_done = !tie0 && m_busy && (m_first || m_cnt >= N - 1);
  assign bus.div_q    = (m_cnt >= N - 1) ? m_q : ~m_q;
  assign bus.div_a    = (m_cnt >= N - 1) ? m_a : ~m_a;

  always @(posedge clock) begin
    if (reset) load_cnt <= 0;
    else if (bus.div_load) load_cnt <= load_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { int id; int q; int r; int dz; int to; } exp_t;
  exp_t sb[$];

  // Scoreboard: compare every accepted response with the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_id", bus.resp_id, e.id);
        chk("resp_quotient", bus.resp_quotient, e.q);
        chk("resp_remainder", bus.resp_remainder, e.r);
        chk("resp_divzero", bus.resp_divzero, e.dz);
        chk("resp_timeout", bus.resp_timeout, e.to);
      end
    end
  end

  task automatic push_exp(input int id, q, r, dz, to);
    exp_t e;
    e = '{id, q, r, dz, to};
    sb.push_back(e);
  endtask

  task automatic set_ops(input int id, dvd, dvs);
    bus.req_dividend[id*N +: N] = N'(dvd);
    bus.req_divisor[id*N +: N]  = N'(dvs);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle resp_valid is seen.
  task automatic wait_resp(input int limit, output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < limit) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus.resp_valid) chk("resp_wait_expired", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Single request, checked grant, exact latency, load pulse count.
  task automatic do_req(input int id, dvd, dvs, q, r, dz, to, lat_exp);
    int lat;
    int l0;
    bus.req_valid = R'(1 << id);
    set_ops(id, dvd, dvs);
    #1;
    chk("req_ready_same_cycle", bus.req_ready, 1 << id);
    push_exp(id, q, r, dz, to);
    l0 = load_cnt;
    @(posedge clock); #1;
    bus.req_valid = '0;
    wait_resp(40, lat);
    chk("latency", lat + 1, lat_exp);
    chk("div_load_pulses", load_cnt - l0, dz ? 0 : 1);
    @(posedge clock); #1;
    chk("flags_cleared", {bus.resp_divzero, bus.resp_timeout, bus.resp_valid}, 0);
  endtask

  typedef struct { int id; int dvd; int dvs; int q; int r; int dz; } vec_t;
  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;
    int seen;
    checks   = 0;
    failures = 0;
    tie0     = 1'b0;
    reset    = 1'b1;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.resp_ready   = 1'b1;

    vt[0] = '{0,  7, 2,  3, 1, 0};
    vt[1] = '{1, 15, 3,  5, 0, 0};
    vt[2] = '{2,  9, 4,  2, 1, 0};
    vt[3] = '{3,  5, 0, 15, 5, 1};
    vt[4] = '{0,  3, 7,  0, 3, 0};
    vt[5] = '{1,  0, 0, 15, 0, 1};
    vt[6] = '{2, 14, 1, 14, 0, 0};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_div_load", bus.div_load, 0);
    chk("rst_div_dividend", bus.div_dividend, 0);
    chk("rst_div_divisor", bus.div_divisor, 0);
    chk("rst_resp_data", {bus.resp_quotient, bus.resp_remainder}, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_flags", {bus.resp_divzero, bus.resp_timeout}, 0);

    // Table of isolated requests, including divide-by-zero.
    for (int i = 0; i < 7; i++)
      do_req(vt[i].id, vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].r, vt[i].dz, 0,
             vt[i].dz ? 1 : N + 2);

    // Round robin with all requesters held: 0,1,2,3,0.
    pulse_reset();
    for (int i = 0; i < R; i++) set_ops(i, 8 + i, i + 1);
    bus.req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (bus.req_ready == 0 && w < 40) begin
        @(posedge clock); #2;
        w++;
      end
      chk("rr_grant", bus.req_ready, 1 << (g % R));
      case (g % R)
        0: push_exp(0, 8, 0, 0, 0);
        1: push_exp(1, 4, 1, 0, 0);
        2: push_exp(2, 3, 1, 0, 0);
        default: push_exp(3, 2, 3, 0, 0);
      endcase
      @(posedge clock); #1;
      if (g == 4) bus.req_valid = '0;
    end
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clock); #1;
      w++;
    end
    chk("rr_all_responded", sb.size(), 0);
    @(posedge clock); #1;

    // Back-pressure: result held 5 cycles, no grant while waiting.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0010;
    set_ops(1, 6, 4);
    #1;
    chk("stall_grant", bus.req_ready, 4'b0010);
    push_exp(1, 1, 2, 0, 0);
    @(posedge clock); #1;
    bus.req_valid = 4'b0001;
    set_ops(0, 13, 5);
    wait_resp(40, lat);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", bus.resp_valid, 1);
      chk("stall_data", {bus.resp_id, bus.resp_quotient, bus.resp_remainder}, {2'd1, 4'd1, 4'd2});
      chk("stall_no_ready", bus.req_ready, 0);
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("handshake_no_grant", bus.req_ready, 0);
    push_exp(0, 2, 3, 0, 0);
    @(posedge clock); #1;
    chk("idle_after_hs", bus.resp_valid, 0);
    chk("grant_after_hs", bus.req_ready, 4'b0001);
    @(posedge clock); #1;
    bus.req_valid = '0;
    wait_resp(40, lat);
    @(posedge clock); #1;

    // Reset during RUN: operation abandoned, pointer back to 0.
    bus.req_valid = 4'b0100;
    set_ops(2, 12, 5);
    #1;
    chk("abort_grant", bus.req_ready, 4'b0100);
    @(posedge clock); #1;
    bus.req_valid = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_rst_valid", bus.resp_valid, 0);
    chk("abort_rst_dividend", bus.div_dividend, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.resp_valid) seen++;
      @(posedge clock); #1;
    end
    chk("abort_no_resp", seen, 0);
    bus.req_valid = 4'b1001;
    set_ops(0, 12, 5);
    set_ops(3, 1, 1);
    #1;
    chk("post_reset_grant0", bus.req_ready, 4'b0001);
    push_exp(0, 2, 2, 0, 0);
    @(posedge clock); #1;
    bus.req_valid = '0;
    wait_resp(40, lat);
    chk("post_reset_latency", lat + 1, N + 2);
    @(posedge clock); #1;

    // Watchdog: divider never finishes.
    tie0 = 1'b1;
    do_req(3, 9, 2, 0, 0, 0, 1, TMO + 2);
    tie0 = 1'b0;

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
